// File: rtl/block_sequencer_pkg.sv
// rtl/block_sequencer_pkg.sv - shared types and widths for the block sequencer and block reader
package block_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EMIT
  } seq_state_t;

  localparam int MAX_NOTES    = 4;
  localparam int BLOCK_IDX_W  = 9;
  localparam int BLOCK_SIZE_W = 3;
  localparam int SONG_W       = 5;
  localparam int NOTE_IDX_W   = 2;

  // Reader sizes above MAX_NOTES are saturated rather than wrapped.
  function automatic logic [BLOCK_SIZE_W-1:0] clamp_size(input logic [BLOCK_SIZE_W-1:0] raw);
    return (raw > BLOCK_SIZE_W'(MAX_NOTES)) ? BLOCK_SIZE_W'(MAX_NOTES) : raw;
  endfunction

endpackage

// File: rtl/block_note_buffer.sv
// rtl/block_note_buffer.sv - captured notes of one block, note index and last-note flag
module block_note_buffer
  import block_sequencer_pkg::*;
#(
  parameter int NOTE_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    capture_i,
  input  logic                    advance_i,
  input  logic [NOTE_W-1:0]       note0_i,
  input  logic [NOTE_W-1:0]       note1_i,
  input  logic [NOTE_W-1:0]       note2_i,
  input  logic [NOTE_W-1:0]       note3_i,
  input  logic [BLOCK_SIZE_W-1:0] size_i,
  output logic [NOTE_W-1:0]       note_o,
  output logic                    last_o
);

  logic [NOTE_W-1:0]       notes_q [MAX_NOTES];
  logic [BLOCK_SIZE_W-1:0] size_q;
  logic [NOTE_IDX_W-1:0]   idx_q;
  logic [NOTE_IDX_W-1:0]   idx_d;

  always_comb begin
    idx_d = idx_q;
    if (capture_i) begin
      idx_d = '0;
    end else if (advance_i) begin
      idx_d = idx_q + NOTE_IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_NOTES; i++) begin
        notes_q[i] <= '0;
      end
      size_q <= '0;
      idx_q  <= '0;
    end else begin
      if (capture_i) begin
        notes_q[0] <= note0_i;
        notes_q[1] <= note1_i;
        notes_q[2] <= note2_i;
        notes_q[3] <= note3_i;
        size_q     <= clamp_size(size_i);
      end
      idx_q <= idx_d;
    end
  end

  assign note_o = notes_q[idx_q];
  assign last_o = (BLOCK_SIZE_W'(idx_q) == (size_q - BLOCK_SIZE_W'(1)));

endmodule

// File: rtl/block_sequencer.sv
// rtl/block_sequencer.sv - walks a song's blocks through the reader and streams their notes
module block_sequencer
  import block_sequencer_pkg::*;
#(
  parameter int BLOCKS_PER_SONG = 16,
  parameter int READ_LATENCY    = 1,
  parameter int NOTE_W          = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic [SONG_W-1:0]       song_sel,
  input  logic                    loop_en,
  output logic [BLOCK_IDX_W-1:0]  block_idx_out,
  input  logic [NOTE_W-1:0]       note0_in,
  input  logic [NOTE_W-1:0]       note1_in,
  input  logic [NOTE_W-1:0]       note2_in,
  input  logic [NOTE_W-1:0]       note3_in,
  input  logic [BLOCK_SIZE_W-1:0] block_size_in,
  output logic [NOTE_W-1:0]       note_out,
  output logic                    note_valid,
  input  logic                    note_ready,
  output logic                    busy,
  output logic                    done
);

  localparam int              CNT_W       = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(READ_LATENCY);
  localparam logic [3:0]      LAST_OFFSET = 4'(BLOCKS_PER_SONG - 1);

  seq_state_t              state_q;
  logic [SONG_W-1:0]       song_q;
  logic [BLOCK_IDX_W-1:0]  blk_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    done_q;

  logic                    fetch_ready;
  logic                    terminator;
  logic                    xfer;
  logic                    last_note;
  logic                    capture;
  logic                    advance;
  logic                    song_end;

  function automatic logic [BLOCK_IDX_W-1:0] song_base(input logic [SONG_W-1:0] s);
    return BLOCK_IDX_W'(int'(s) * BLOCKS_PER_SONG);
  endfunction

  assign fetch_ready = (state_q == FETCH) && (cnt_q == '0);
  assign terminator  = (clamp_size(block_size_in) == '0);
  assign xfer        = (state_q == EMIT) && note_ready;
  assign capture     = fetch_ready && !stop;
  assign advance     = xfer && !last_note && !stop;
  // A zero-size block ends the song exactly like the last note of the final block.
  assign song_end    = (fetch_ready && terminator) ||
                       (xfer && last_note && (blk_q[3:0] == LAST_OFFSET));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      song_q  <= '0;
      blk_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (stop) begin
        state_q <= IDLE;
      end else if (song_end) begin
        if (loop_en) begin
          blk_q   <= song_base(song_q);
          cnt_q   <= CNT_LOAD;
          state_q <= FETCH;
        end else begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              song_q  <= song_sel;
              blk_q   <= song_base(song_sel);
              cnt_q   <= CNT_LOAD;
              state_q <= FETCH;
            end
          end
          FETCH: begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - CNT_W'(1);
            end else begin
              state_q <= EMIT;
            end
          end
          EMIT: begin
            if (xfer && last_note) begin
              blk_q   <= blk_q + BLOCK_IDX_W'(1);
              cnt_q   <= CNT_LOAD;
              state_q <= FETCH;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  block_note_buffer #(
    .NOTE_W(NOTE_W)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .capture_i(capture),
    .advance_i(advance),
    .note0_i  (note0_in),
    .note1_i  (note1_in),
    .note2_i  (note2_in),
    .note3_i  (note3_in),
    .size_i   (block_size_in),
    .note_o   (note_out),
    .last_o   (last_note)
  );

  assign block_idx_out = blk_q;
  assign note_valid    = (state_q == EMIT);
  assign busy          = (state_q != IDLE);
  assign done          = done_q;

endmodule

// File: doc/block_sequencer.md
# block_sequencer

Song playback sequencer upstream of `top_block_reader`. Given a song number, it walks that song's 16 blocks in order and drives the block index. It waits out the reader's latency, then captures the block's notes and size. It emits the notes one at a time on a valid/ready stream toward the synthesis/analysis stage.

## Interface
- `BLOCKS_PER_SONG`, 16: blocks per song; song base index = song × BLOCKS_PER_SONG.
- `READ_LATENCY`, 1: clock edges from a `block_idx_out` change to valid reader outputs.
- `NOTE_W`, 16: note word width.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; one clock, asynchronous, active-high.
- `start`  in  1  pulse; begin playback of `song_sel`; ignored while `busy`.
- `stop`  in  1  pulse; abort playback; has priority over every other event.
- `song_sel`  in  5  song number 0–31, latched on accepted `start`.
- `loop_en`  in  1  sampled at song end; 1 = restart same song.
- `block_idx_out`  out  9  block index to reader `block_idx_in`; registered.
- `note0_in`..`note3_in`  in  NOTE_W each  reader notes.
- `block_size_in`  in  3  reader block size (number of valid notes). The reader's `prev_block_size` is not consumed.
- `note_out`  out  NOTE_W  current note.
- `note_valid`  out  1  `note_out` valid.
- `note_ready`  in  1  consumer accepts; transfer = `note_valid` & `note_ready`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at natural song end with `loop_en`=0.

## Operation
- **States:** IDLE, FETCH, EMIT.
- **IDLE:**
  - On `start`: latch song, set `block_idx_out` = song×16, set wait counter = READ_LATENCY, go to FETCH.
- **FETCH:**
  - While counter ≠ 0, decrement.
  - At the edge where counter = 0, register `note0_in`..`note3_in` and the effective size, clear the note index, then:
    - Effective size = `block_size_in` clamped to 4; values 5–7 become 4.
    - Effective size 0 is a song terminator and is treated as song end.
    - Otherwise go to EMIT.
- **EMIT:**
  - `note_out` = captured note[index], `note_valid`=1.
  - On transfer with index < size−1: increment index.
  - On transfer of the last note:
    - If block offset < 15: `block_idx_out`+1, counter = READ_LATENCY, go to FETCH.
    - If block offset = 15: song end.
- **Song end:**
  - If `loop_en`: `block_idx_out` = song base, go to FETCH.
  - Otherwise: pulse `done`, go to IDLE; `block_idx_out` holds its last value.
- **`stop` in any state:** go to IDLE at that edge; `note_valid` low the next cycle; no `done`.
- Block offset is `block_idx_out[3:0]`. The index never crosses into the next song.

## Timing
- **Reset values:**
  - `block_idx_out`=0, `note_out`=0, `note_valid`=0, `busy`=0, `done`=0.
  - State IDLE, latched song 0.
- **Latency:** `start` sampled at edge E0. `block_idx_out` is valid after E0, capture happens at edge E0+READ_LATENCY+1, and `note_valid` rises after that edge. With the default this is 2 edges after E0.
- **Stream:**
  - `note_out` is stable while `note_valid` & !`note_ready`.
  - `note_valid` never drops without a transfer, except on `stop` or `rst`.
  - One transfer per cycle maximum; consecutive notes within a block are back-to-back when `note_ready`=1.
- **Inter-block gap:** READ_LATENCY+1 cycles with `note_valid`=0.
- **Simultaneous events:**
  - `stop` & `start` in IDLE: stay IDLE.
  - `start` while busy is ignored.
  - Terminator at block offset 0: song end with no notes emitted. `done` pulses if `loop_en`=0; if `loop_en`=1 it refetches the same block indefinitely, which is intended and documented.
- **Reset mid-operation:** all outputs return to reset values asynchronously.

## Structure
- A shared package holds:
  - the state enum `seq_state_t` (IDLE/FETCH/EMIT);
  - `MAX_NOTES`=4;
  - `BLOCK_IDX_W`=9, `BLOCK_SIZE_W`=3, `SONG_W`=5.
- The package is shared with `top_block_reader`.
- One natural sub-module, `block_note_buffer`: a 4-entry capture register with clamped size, note index counter, output mux and a last-note flag.
- FSM, wait counter and index arithmetic stay in `block_sequencer`.

## Test plan
- **Basic playback:** reset, `song_sel`=0, `start`, `note_ready`=1 → `block_idx_out` 0,1,2,…15. Each block emits exactly `block_size_in` notes matching the reader words in order. `done` pulses once after block 15's last note, then `busy`=0.
- **Backpressure:** song 1, `note_ready` toggled 1/0 each cycle → `block_idx_out` starts at 16. `note_out` holds steady while stalled, with no duplicated or lost notes. Block 20's notes are identical to a direct reader read of index 20.
- **Size edge cases:**
  - Reader model returns size 7 → exactly 4 notes.
  - Size 0 at block 24 (offset 8) → no notes from it, `done` pulses, `block_idx_out` stays 24.
- **Loop:** `loop_en`=1, song 0 → after block 15's last transfer, `block_idx_out` returns to 0 and block 0's notes repeat; `done` never pulses.
- **Stop and restart:** `stop` mid-EMIT → `note_valid`=0 next cycle, `busy`=0, no `done`. A new `start`, `song_sel`=2, resumes at index 32 with first `note_valid` 2 edges after `start`.
- **Async reset:** assert `rst` mid-FETCH between clock edges → all outputs at reset values immediately. `start` during busy is ignored; measured inter-block gap is 2 cycles at READ_LATENCY=1.
